// File: rtl/bpu_gshare_upd_queue_pkg.sv
// Shared BPU definitions: PHT index width and 2-bit counter encodings.
// Also holds the per-entry payload kept by the gshare update queue.
`ifndef GHR_PHT_IDX_WIDTH
`define GHR_PHT_IDX_WIDTH 11
`endif

package bpu_gshare_upd_queue_pkg;

  localparam int unsigned PHT_IDX_W = `GHR_PHT_IDX_WIDTH;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Prediction-time state captured for each in-flight branch
  typedef struct packed {
    logic       pred;
    logic [1:0] entry;
  } pq_meta_t;

endpackage

// File: rtl/bpu_sat_ctr2.sv
// Saturating 2-bit branch counter next-state (SNT/WNT/WT/ST).
module bpu_sat_ctr2
  import bpu_gshare_upd_queue_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != CTR_ST) nxt = cur + 2'(1);
    end else begin
      if (cur != CTR_SNT) nxt = cur - 2'(1);
    end
  end

endmodule

// File: rtl/bpu_gshare_upd_queue.sv
// In-order queue of gshare predictions; retires the head on resolve and issues a registered PHT update.
// Optional macro BPU_GSHARE_UPD_BYPASS_EN forwards the just-issued counter to a back-to-back update of the same index.
`ifndef GHR_PHT_IDX_WIDTH
`define GHR_PHT_IDX_WIDTH 11
`endif

module bpu_gshare_upd_queue
  import bpu_gshare_upd_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = `GHR_PHT_IDX_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_pq_push_vld,
  output logic                       o_pq_push_rdy,
  input  logic [IDX_W-1:0]           i_pq_pht_idx,
  input  logic [1:0]                 i_pq_pht_entry,
  input  logic                       i_pq_pred_taken,
  input  logic                       i_pq_rslv_vld,
  input  logic                       i_pq_rslv_taken,
  input  logic                       i_pq_flush,
  output logic                       o_gs_wren,
  output logic                       o_gs_tsucc,
  output logic [IDX_W-1:0]           o_gs_update_pht_idx,
  output logic [1:0]                 o_gs_update_pht_entry,
  output logic                       o_pq_mispred,
  output logic [$clog2(DEPTH):0]     o_pq_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] idx_mem  [DEPTH];
  pq_meta_t         meta_mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  logic             push_acc;
  logic             rslv_acc;
  logic [IDX_W-1:0] head_idx;
  pq_meta_t         head_meta;
  logic [1:0]       ctr_base;
  logic [1:0]       ctr_nxt;

  assign o_pq_push_rdy = (o_pq_cnt != CNT_W'(DEPTH));
  // Flush wins over push; resolve on empty is a no-op
  assign push_acc  = i_pq_push_vld && o_pq_push_rdy && !i_pq_flush;
  assign rslv_acc  = i_pq_rslv_vld && (o_pq_cnt != '0);
  assign head_idx  = idx_mem[head];
  assign head_meta = meta_mem[head];

`ifdef BPU_GSHARE_UPD_BYPASS_EN
  assign ctr_base = (o_gs_wren && (head_idx == o_gs_update_pht_idx)) ?
                    o_gs_update_pht_entry : head_meta.entry;
`else
  assign ctr_base = head_meta.entry;
`endif

  bpu_sat_ctr2 u_sat_ctr2 (
    .cur   (ctr_base),
    .taken (i_pq_rslv_taken),
    .nxt   (ctr_nxt)
  );

  // Entry storage needs no reset; occupancy tracks validity
  always_ff @(posedge clk) begin
    if (!rst && push_acc) begin
      idx_mem[tail]  <= i_pq_pht_idx;
      meta_mem[tail] <= '{pred: i_pq_pred_taken, entry: i_pq_pht_entry};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head                  <= '0;
      tail                  <= '0;
      o_pq_cnt              <= '0;
      o_gs_wren             <= 1'b0;
      o_gs_tsucc            <= 1'b0;
      o_gs_update_pht_idx   <= '0;
      o_gs_update_pht_entry <= '0;
      o_pq_mispred          <= 1'b0;
    end else begin
      o_gs_wren    <= rslv_acc;
      o_pq_mispred <= rslv_acc && (i_pq_rslv_taken != head_meta.pred);
      if (rslv_acc) begin
        o_gs_tsucc            <= i_pq_rslv_taken;
        o_gs_update_pht_idx   <= head_idx;
        o_gs_update_pht_entry <= ctr_nxt;
      end
      if (i_pq_flush) begin
        head     <= '0;
        tail     <= '0;
        o_pq_cnt <= '0;
      end else begin
        if (push_acc) tail <= tail + PTR_W'(1);
        if (rslv_acc) head <= head + PTR_W'(1);
        case ({push_acc, rslv_acc})
          2'b10:   o_pq_cnt <= o_pq_cnt + CNT_W'(1);
          2'b01:   o_pq_cnt <= o_pq_cnt - CNT_W'(1);
          default: o_pq_cnt <= o_pq_cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bpu_gshare_upd_queue.sv
// Directed table-driven bench for bpu_gshare_upd_queue (DEPTH=8, IDX_W=11).
module tb_bpu_gshare_upd_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_vld;
  logic        push_rdy;
  logic [10:0] pht_idx;
  logic [1:0]  pht_entry;
  logic        pred_taken;
  logic        rslv_vld;
  logic        rslv_taken;
  logic        flush;
  logic        gs_wren;
  logic        gs_tsucc;
  logic [10:0] upd_idx;
  logic [1:0]  upd_entry;
  logic        mispred;
  logic [3:0]  cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic        push;
    logic [10:0] idx;
    logic [1:0]  ent;
    logic        pred;
    logic        rslv;
    logic        rtk;
    logic        flush;
    logic        e_wren;
    logic        e_tsucc;
    logic [10:0] e_idx;
    logic [1:0]  e_ent;
    logic        e_mis;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  bpu_gshare_upd_queue #(.DEPTH(8), .IDX_W(11)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .i_pq_push_vld         (push_vld),
    .o_pq_push_rdy         (push_rdy),
    .i_pq_pht_idx          (pht_idx),
    .i_pq_pht_entry        (pht_entry),
    .i_pq_pred_taken       (pred_taken),
    .i_pq_rslv_vld         (rslv_vld),
    .i_pq_rslv_taken       (rslv_taken),
    .i_pq_flush            (flush),
    .o_gs_wren             (gs_wren),
    .o_gs_tsucc            (gs_tsucc),
    .o_gs_update_pht_idx   (upd_idx),
    .o_gs_update_pht_entry (upd_entry),
    .o_pq_mispred          (mispred),
    .o_pq_cnt              (cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic p, input logic [10:0] i,
                              input logic [1:0] e, input logic pd, input logic rv,
                              input logic rt, input logic f, input logic ew,
                              input logic et, input logic [10:0] ei, input logic [1:0] ee,
                              input logic em, input logic [3:0] ec);
    vec_t v;
    v.rst = r; v.push = p; v.idx = i; v.ent = e; v.pred = pd;
    v.rslv = rv; v.rtk = rt; v.flush = f;
    v.e_wren = ew; v.e_tsucc = et; v.e_idx = ei; v.e_ent = ee;
    v.e_mis = em; v.e_cnt = ec;
    return v;
  endfunction

  // Drive one cycle, then sample 1ns after the rising edge
  task automatic run(input vec_t v, input string name);
    logic ok;
    logic e_rdy;
    rst = v.rst; push_vld = v.push; pht_idx = v.idx; pht_entry = v.ent;
    pred_taken = v.pred; rslv_vld = v.rslv; rslv_taken = v.rtk; flush = v.flush;
    @(posedge clk);
    #1;
    e_rdy = (v.e_cnt != 4'd8);
    ok = (gs_wren === v.e_wren) && (mispred === v.e_mis) &&
         (cnt === v.e_cnt) && (push_rdy === e_rdy);
    if (v.e_wren || v.rst)
      ok = ok && (gs_tsucc === v.e_tsucc) && (upd_idx === v.e_idx) && (upd_entry === v.e_ent);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got wren=%b tsucc=%b idx=%h ent=%b mis=%b cnt=%0d rdy=%b; want wren=%b tsucc=%b idx=%h ent=%b mis=%b cnt=%0d rdy=%b",
               name, gs_wren, gs_tsucc, upd_idx, upd_entry, mispred, cnt, push_rdy,
               v.e_wren, v.e_tsucc, v.e_idx, v.e_ent, v.e_mis, v.e_cnt, e_rdy);
    end
  endtask

  task automatic idle(input logic [3:0] c, input string name);
    run(mk(0,0,11'h0,2'b00,0, 0,0,0, 0,0,11'h0,2'b00,0,c), name);
  endtask

  initial begin
    // rst push idx ent pred rslv rtk flush | wren tsucc idx ent mis cnt
    tbl.push_back(mk(1,0,11'h000,2'b00,0, 0,0,0, 0,0,11'h000,2'b00,0,4'd0));
    tbl.push_back(mk(0,1,11'h155,2'b01,0, 0,0,0, 0,0,11'h000,2'b00,0,4'd1));
    tbl.push_back(mk(0,0,11'h000,2'b00,0, 1,1,0, 1,1,11'h155,2'b10,1,4'd0));
    tbl.push_back(mk(0,0,11'h000,2'b00,0, 0,0,0, 0,0,11'h000,2'b00,0,4'd0));
    tbl.push_back(mk(0,0,11'h000,2'b00,0, 1,1,0, 0,0,11'h000,2'b00,0,4'd0));
    tbl.push_back(mk(0,1,11'h3FF,2'b11,1, 0,0,0, 0,0,11'h000,2'b00,0,4'd1));
    tbl.push_back(mk(0,1,11'h000,2'b00,0, 0,0,0, 0,0,11'h000,2'b00,0,4'd2));
    tbl.push_back(mk(0,0,11'h000,2'b00,0, 1,1,0, 1,1,11'h3FF,2'b11,0,4'd1));
    tbl.push_back(mk(0,0,11'h000,2'b00,0, 1,0,0, 1,0,11'h000,2'b00,0,4'd0));
    tbl.push_back(mk(0,1,11'h0AA,2'b10,1, 1,0,0, 0,0,11'h000,2'b00,0,4'd1));
    tbl.push_back(mk(0,1,11'h0AB,2'b01,0, 1,0,0, 1,0,11'h0AA,2'b01,1,4'd1));
    tbl.push_back(mk(0,0,11'h000,2'b00,0, 1,1,0, 1,1,11'h0AB,2'b10,1,4'd0));

    for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("vec%0d", i));

    // Fill to full, drop a push, then push+resolve at full drops the push
    for (int i = 0; i < 8; i++)
      run(mk(0,1,11'(16+i),2'(i),0, 0,0,0, 0,0,11'h0,2'b00,0,4'(i+1)), "fill");
    run(mk(0,1,11'h7FF,2'b11,1, 0,0,0, 0,0,11'h0,2'b00,0,4'd8), "full_drop");
    run(mk(0,1,11'h7FE,2'b11,1, 1,1,0, 1,1,11'd16,2'b01,1,4'd7), "full_push_rslv");
    for (int i = 1; i < 8; i++) begin
      logic [1:0] e;
      e = 2'(i);
      run(mk(0,0,11'h0,2'b00,0, 1,0,0, 1,0,11'(16+i),(e == 2'b00) ? 2'b00 : e - 2'b01,0,4'(7-i)),
          "drain");
    end
    run(mk(0,0,11'h0,2'b00,0, 1,1,0, 0,0,11'h0,2'b00,0,4'd0), "drain_empty");

    // Flush with a same-cycle resolve and push
    for (int i = 0; i < 3; i++)
      run(mk(0,1,11'(256+i),2'b01,1, 0,0,0, 0,0,11'h0,2'b00,0,4'(i+1)), "flush_fill");
    run(mk(0,1,11'h111,2'b00,0, 1,1,1, 1,1,11'h100,2'b10,0,4'd0), "flush_rslv");
    idle(4'd0, "flush_after");
    run(mk(0,1,11'h050,2'b00,0, 0,0,0, 0,0,11'h0,2'b00,0,4'd1), "flush_refill");
    run(mk(0,0,11'h0,2'b00,0, 1,0,0, 1,0,11'h050,2'b00,0,4'd0), "flush_no_stale");

    // Pending update visible while flush is raised the following cycle
    run(mk(0,1,11'h060,2'b10,0, 0,0,0, 0,0,11'h0,2'b00,0,4'd1), "pend_push0");
    run(mk(0,1,11'h061,2'b10,0, 0,0,0, 0,0,11'h0,2'b00,0,4'd2), "pend_push1");
    run(mk(0,0,11'h0,2'b00,0, 1,1,0, 1,1,11'h060,2'b11,1,4'd1), "pend_rslv");
    run(mk(0,0,11'h0,2'b00,0, 0,0,1, 0,0,11'h0,2'b00,0,4'd0), "pend_flush");

    // Back-to-back updates to the same index
    run(mk(0,1,11'h010,2'b10,1, 0,0,0, 0,0,11'h0,2'b00,0,4'd1), "b2b_push0");
    run(mk(0,1,11'h010,2'b10,1, 0,0,0, 0,0,11'h0,2'b00,0,4'd2), "b2b_push1");
    run(mk(0,0,11'h0,2'b00,0, 1,1,0, 1,1,11'h010,2'b11,0,4'd1), "b2b_rslv0");
    run(mk(0,0,11'h0,2'b00,0, 1,1,0, 1,1,11'h010,2'b11,0,4'd0), "b2b_rslv1");
    run(mk(0,1,11'h010,2'b01,1, 0,0,0, 0,0,11'h0,2'b00,0,4'd1), "b2b01_push0");
    run(mk(0,1,11'h010,2'b01,1, 0,0,0, 0,0,11'h0,2'b00,0,4'd2), "b2b01_push1");
    run(mk(0,0,11'h0,2'b00,0, 1,1,0, 1,1,11'h010,2'b10,0,4'd1), "b2b01_rslv0");
`ifdef BPU_GSHARE_UPD_BYPASS_EN
    run(mk(0,0,11'h0,2'b00,0, 1,1,0, 1,1,11'h010,2'b11,0,4'd0), "b2b01_rslv1");
`else
    run(mk(0,0,11'h0,2'b00,0, 1,1,0, 1,1,11'h010,2'b10,0,4'd0), "b2b01_rslv1");
`endif

    // Reset overrides everything with 4 entries and an update pending
    for (int i = 0; i < 4; i++)
      run(mk(0,1,11'(512+i),2'b01,1, 0,0,0, 0,0,11'h0,2'b00,0,4'(i+1)), "rst_fill");
    run(mk(0,1,11'h204,2'b01,1, 1,1,0, 1,1,11'h200,2'b10,0,4'd4), "rst_pending");
    run(mk(1,1,11'h205,2'b01,1, 1,1,1, 0,0,11'h000,2'b00,0,4'd0), "rst_override");
    run(mk(0,1,11'h321,2'b11,1, 0,0,0, 0,0,11'h0,2'b00,0,4'd1), "rst_push");
    run(mk(0,0,11'h0,2'b00,0, 1,0,0, 1,0,11'h321,2'b10,1,4'd0), "rst_rslv");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bpu_gshare_upd_queue.md
BPU_GSHARE_UPD_QUEUE -- requirements
Module: bpu_gshare_upd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of in-flight prediction entries (power of 2, at least 2).
REQ-002 SHALL have parameter IDX_W, default `GHR_PHT_IDX_WIDTH (11): PHT index width.
REQ-003 SHALL have port clk  in  1: single clock, all state rising-edge.
REQ-004 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-005 SHALL have port i_pq_push_vld  in  1: fetch pushes a gshare prediction.
REQ-006 SHALL have port o_pq_push_rdy  out  1: queue can accept a push this cycle.
REQ-007 SHALL have port i_pq_pht_idx  in  IDX_W: PHT index used at prediction.
REQ-008 SHALL have port i_pq_pht_entry  in  2: PHT counter read at prediction.
REQ-009 SHALL have port i_pq_pred_taken  in  1: predicted direction.
REQ-010 SHALL have port i_pq_rslv_vld  in  1: oldest branch resolved (in program order).
REQ-011 SHALL have port i_pq_rslv_taken  in  1: actual direction.
REQ-012 SHALL have port i_pq_flush  in  1: discard all unresolved entries.
REQ-013 SHALL have ports o_gs_wren, o_gs_tsucc  out  1 each: PHT/GHR update strobe and outcome.
REQ-014 SHALL have ports o_gs_update_pht_idx  out  IDX_W and o_gs_update_pht_entry  out  2: write index and new counter.
REQ-015 SHALL have port o_pq_mispred  out  1: one-cycle pulse, resolved direction differed from prediction.
REQ-016 SHALL have port o_pq_cnt  out  log2(DEPTH)+1: current occupancy.

Function
REQ-017 SHALL be a circular FIFO with head/tail pointers wrapping modulo DEPTH; push writes at tail, resolve retires head.
REQ-018 SHALL drive o_pq_push_rdy = (cnt != DEPTH), from the current count only; a resolve in the same cycle does not free a slot for a push when full.
REQ-019 SHALL drop a push when i_pq_push_vld && !o_pq_push_rdy, with no state change.
REQ-020 SHALL ignore a resolve when the queue is empty: no write, no mispred pulse.
REQ-021 SHALL compute the new counter from the head entry as saturating 2-bit: taken -> min(e+1,3), not-taken -> max(e-1,0); encoding 00 SNT, 01 WNT, 10 WT, 11 ST.
REQ-022 SHALL register the update: o_gs_wren, o_gs_tsucc, idx and entry are valid exactly 1 cycle after an accepted resolve, for one cycle.
REQ-023 SHALL assert o_pq_mispred in the same cycle as o_gs_wren when rslv_taken != head pred_taken.
REQ-024 SHALL handle a push and a resolve in the same cycle (not full) with cnt unchanged.
REQ-025 SHALL process flush with a same-cycle resolve in this order: resolve retires head and issues its update, then all remaining entries are cleared; a same-cycle push is dropped.
REQ-026 SHALL leave a registered update already pending from the previous cycle unaffected by flush.

Reset
REQ-027 SHALL on rst clear head, tail and cnt to 0 and drive o_gs_wren, o_gs_tsucc, o_pq_mispred, o_gs_update_pht_idx and o_gs_update_pht_entry to 0 on the next cycle, with o_pq_push_rdy = 1.
REQ-028 SHALL let rst override push, resolve and flush, and discard any pending update.

Configuration
REQ-029 SHALL, with BPU_GSHARE_UPD_BYPASS_EN defined, use the just-issued o_gs_update_pht_entry instead of the stored head entry as the counter base when o_gs_wren=1 and the head idx equals o_gs_update_pht_idx.
REQ-030 SHALL, without BPU_GSHARE_UPD_BYPASS_EN, always use the stored entry, so back-to-back updates to one index may lose a step.

Structure
REQ-031 SHALL take IDX width and the counter encodings (SNT/WNT/WT/ST) from the shared BPU defines header.
REQ-032 SHALL implement the counter next-state in a combinational sub-module bpu_sat_ctr2 (inputs cur[1:0], taken; output nxt[1:0]).

Verification
REQ-033 SHALL cover: push idx=0x155, entry=01, pred=0, then resolve taken=1 -> next cycle wren=1, idx=0x155, entry=10, tsucc=1, mispred=1.
REQ-034 SHALL cover: 8 pushes -> cnt=8, push_rdy=0; 9th push dropped; one resolve -> cnt=7, push_rdy=1.
REQ-035 SHALL cover: entry=11 resolved taken -> 11, and entry=00 resolved not-taken -> 00, mispred=0.
REQ-036 SHALL cover: 3 entries, flush+resolve in the same cycle -> exactly one wren, cnt=0 next cycle.
REQ-037 SHALL cover: two entries idx=0x010, entry=10, both resolved taken back-to-back -> second write 11 with BPU_GSHARE_UPD_BYPASS_EN, 11 without it; repeat with base 01 -> 11 with bypass, 10 without.
REQ-038 SHALL cover: rst asserted with 4 entries and an update pending -> next cycle wren=0, cnt=0, push_rdy=1.
